ov_window_meter: RTL and testbench

//  Downstream consumer of the counter's ov pulse. Counts ov pulses over a fixed window of WIN clk cycles.
//  At each window end it publishes the count on a valid/ready output register.

---
 rtl/ov_window_meter.sv | 122 ++++++++++++
 tb/tb_ov_window_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov_window_meter.sv
// ov_window_meter: counts ov pulses over back-to-back windows of WIN cycles and
// publishes each window's count on a valid/ready output register.
// Optional feature macro: OVW_OVERRUN_EN adds the sticky overrun flag and port.
module ov_window_meter #(
  parameter int unsigned W   = 8,
  parameter int unsigned WIN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ov,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef OVW_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  localparam int unsigned WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(WIN - 1);
  localparam logic [W-1:0]   EMAX  = {W{1'b1}};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t         state, state_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [W-1:0]   ecnt, ecnt_n;
  logic [W-1:0]   ecnt_inc;
  logic [W-1:0]   data_n;
  logic           valid_n;
  logic           win_end;
`ifdef OVW_OVERRUN_EN
  logic           ovr_n;
`endif

  // Next-state, window/event counting and output-register handshake
  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    ecnt_n   = ecnt;
    data_n   = out_data;
    valid_n  = out_valid;
`ifdef OVW_OVERRUN_EN
    ovr_n    = overrun;
`endif
    ecnt_inc = ecnt;
    if (ov && (ecnt != EMAX)) ecnt_inc = ecnt + W'(1);
    win_end  = (state == COUNT) && en && (wcnt == WLAST);

    case (state)
      IDLE: begin
        wcnt_n = '0;
        ecnt_n = '0;
        if (en) state_n = COUNT;
      end
      COUNT: begin
        if (!en) begin
          // partial window is discarded
          state_n = IDLE;
          wcnt_n  = '0;
          ecnt_n  = '0;
        end else if (win_end) begin
          wcnt_n = '0;
          ecnt_n = '0;
        end else begin
          wcnt_n = wcnt + WCW'(1);
          ecnt_n = ecnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase

    // closing window's last ov is included; latest result wins over unread one
    if (win_end) begin
      data_n  = ecnt_inc;
      valid_n = 1'b1;
`ifdef OVW_OVERRUN_EN
      if (out_valid && !out_ready) ovr_n = 1'b1;
`endif
    end else if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end

    if (clr) begin
      state_n = IDLE;
      wcnt_n  = '0;
      ecnt_n  = '0;
      data_n  = '0;
      valid_n = 1'b0;
`ifdef OVW_OVERRUN_EN
      ovr_n   = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      ecnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef OVW_OVERRUN_EN
      overrun   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      ecnt      <= ecnt_n;
      out_data  <= data_n;
      out_valid <= valid_n;
`ifdef OVW_OVERRUN_EN
      overrun   <= ovr_n;
`endif
    end
  end

endmodule

// File: tb/tb_ov_window_meter.sv
// Self-checking bench for ov_window_meter: a W=8 and a W=3 instance share stimulus;
// results are checked through per-instance expected-value queues at each transfer.
module tb_ov_window_meter;

  localparam int unsigned WIN = 16;

  logic       clk = 1'b0;
  logic       rst, ov, en, clr, out_ready;
  logic [7:0] data8;
  logic       valid8;
  logic [2:0] data3;
  logic       valid3;
`ifdef OVW_OVERRUN_EN
  logic       overrun8, overrun3;
`endif

  int n_vec = 0;
  int n_err = 0;
  int q8[$];
  int q3[$];

  typedef struct {
    logic [15:0] mask;
    int          exp8;
    int          exp3;
  } vec_t;
  vec_t vecs[8];

  ov_window_meter #(.W(8), .WIN(WIN)) u_dut8 (
    .clk(clk), .rst(rst), .ov(ov), .en(en), .clr(clr),
    .out_data(data8), .out_valid(valid8), .out_ready(out_ready)
`ifdef OVW_OVERRUN_EN
    , .overrun(overrun8)
`endif
  );

  ov_window_meter #(.W(3), .WIN(WIN)) u_dut3 (
    .clk(clk), .rst(rst), .ov(ov), .en(en), .clr(clr),
    .out_data(data3), .out_valid(valid3), .out_ready(out_ready)
`ifdef OVW_OVERRUN_EN
    , .overrun(overrun3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare each transferred result against the oldest expected one
  task automatic monitor();
    if (!rst && out_ready) begin
      if (valid8 === 1'b1) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious8: got result %0d expected none at %0t", data8, $time);
        end else chk("result8", int'(data8), q8.pop_front());
      end
      if (valid3 === 1'b1) begin
        if (q3.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious3: got result %0d expected none at %0t", data3, $time);
        end else chk("result3", int'(data3), q3.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [15:0] m);
    for (int k = 0; k < 16; k++) begin
      ov = m[k];
      tick();
    end
    ov = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid8"}, int'(valid8), 0);
    chk({name, "_data8"}, int'(data8), 0);
    chk({name, "_valid3"}, int'(valid3), 0);
    chk({name, "_data3"}, int'(data3), 0);
`ifdef OVW_OVERRUN_EN
    chk({name, "_ovr8"}, int'(overrun8), 0);
    chk({name, "_ovr3"}, int'(overrun3), 0);
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0101, 2, 2};
    vecs[1] = '{16'h0101, 2, 2};
    vecs[2] = '{16'h8000, 1, 1};
    vecs[3] = '{16'h0000, 0, 0};
    vecs[4] = '{16'hFFFF, 16, 7};
    vecs[5] = '{16'h0001, 1, 1};
    vecs[6] = '{16'hAAAA, 8, 7};
    vecs[7] = '{16'h7FFF, 15, 7};

    // reset, then idle with ov toggling
    rst = 1'b1; en = 1'b0; ov = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");
    for (int i = 0; i < 20; i++) begin
      ov = ~ov;
      tick();
    end
    ov = 1'b0;
    chk_zero("idle");

    // back-to-back windows from the vector table
    en = 1'b1;
    tick();
    foreach (vecs[i]) begin
      q8.push_back(vecs[i].exp8);
      q3.push_back(vecs[i].exp3);
      run_window(vecs[i].mask);
      chk("valid_at_end", int'(valid8), 1);
    end
    tick();
    chk("valid_pulse", int'(valid8), 0);
    en = 1'b0;
    tick();

    // two window ends without a consumer: latest wins
    out_ready = 1'b0; en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    run_window(16'h0003);
    chk("ovw_first_valid", int'(valid8), 1);
    chk("ovw_first_data", int'(data8), 2);
`ifdef OVW_OVERRUN_EN
    chk("ovw_first_ovr", int'(overrun8), 0);
`endif
    run_window(16'h0070);
    chk("ovw_valid", int'(valid8), 1);
    chk("ovw_data8", int'(data8), 3);
    chk("ovw_data3", int'(data3), 3);
`ifdef OVW_OVERRUN_EN
    chk("ovw_ovr8", int'(overrun8), 1);
    chk("ovw_ovr3", int'(overrun3), 1);
`endif
    out_ready = 1'b1;
    q8.push_back(3);
    q3.push_back(3);
    tick();
    chk("ovw_consumed", int'(valid8), 0);
    en = 1'b0;
    tick(); tick();
`ifdef OVW_OVERRUN_EN
    chk("ovw_sticky", int'(overrun8), 1);
`endif

    // partial window discarded on en drop
    en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_zero("clr_ovr");
    tick();
    for (int k = 0; k < 9; k++) begin
      ov = (k == 4);
      tick();
    end
    ov = 1'b0; en = 1'b0;
    tick(); tick(); tick();
    chk("partial_none", int'(valid8), 0);
    en = 1'b1;
    tick();
    q8.push_back(2);
    q3.push_back(2);
    run_window(16'h0011);
    chk("after_partial_valid", int'(valid8), 1);
    tick();
    en = 1'b0;
    tick();

    // rst mid-window with an unread result
    out_ready = 1'b0; en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    run_window(16'h0005);
    chk("pre_rst_data", int'(data8), 2);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("mid_rst");

    // clr mid-window with an unread result, then restart
    tick();
    run_window(16'h0003);
    chk("pre_clr_valid", int'(valid8), 1);
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1;
    tick();
    chk_zero("mid_clr");
    clr = 1'b0;
    tick();
    out_ready = 1'b1;
    q8.push_back(2);
    q3.push_back(2);
    run_window(16'h8001);
    chk("restart_valid", int'(valid8), 1);
    tick();
    en = 1'b0;
    tick(); tick();

    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
